// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state type, register map and constants for the PWM motor generator
package pwm_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int PERIOD_MIN = 2;
  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_DUTY0 = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  typedef enum logic [1:0] {IDLE, RUN, FAILSAFE} state_e;
endpackage

// File: rtl/pwm_sync2.sv
// pwm_sync2: two-flop synchroniser with synchronous reset to 0
module pwm_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  end
  assign q = sync_q[1];
endmodule

// File: rtl/pwm_motor_gen.sv
// pwm_motor_gen: four-channel double-buffered ESC/servo PWM generator with throttle watchdog
module pwm_motor_gen
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PERIOD_RST = 3763,
  parameter int FAILSAFE_DUTY = 1505,
  parameter int WDOG_PERIODS = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [2:0]        addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              failsafe
);
  localparam int WD_W = $clog2(WDOG_PERIODS + 1);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] PMIN = CNT_W'(PERIOD_MIN);
  localparam logic [3:0] DUTY_END = 4'(ADDR_DUTY0) + 4'(NUM_CH);
  logic locked_sync;
  state_e state_q, state_d;
  logic enable_q, enable_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rd_data_q, rd_data_d;
  logic [CNT_W-1:0] duty_sh_q [NUM_CH];
  logic [CNT_W-1:0] duty_sh_d [NUM_CH];
  logic [CNT_W-1:0] duty_act_q [NUM_CH];
  logic [CNT_W-1:0] duty_act_d [NUM_CH];
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic duty_addr, duty_wr, tc, go, load;
  logic [IDX_W-1:0] duty_idx;

  pwm_sync2 u_sync (.clk(clk), .rst(rst), .d(pll_locked), .q(locked_sync));

  assign duty_addr = addr >= ADDR_DUTY0 && {1'b0, addr} < DUTY_END;
  assign duty_wr = wr_en && duty_addr;
  assign duty_idx = IDX_W'(addr - ADDR_DUTY0);
  assign go = enable_q && locked_sync;
  assign tc = cnt_q == period_act_q - 1'b1;

  always_comb begin
    enable_d = enable_q;
    period_sh_d = period_sh_q;
    duty_sh_d = duty_sh_q;
    if (wr_en && addr == ADDR_CTRL) enable_d = wr_data[0];
    if (wr_en && addr == ADDR_PERIOD) period_sh_d = wr_data < PMIN ? PMIN : wr_data;
    if (duty_wr) duty_sh_d[duty_idx] = wr_data;
  end

  // shadow_d feeds the active registers so a write on the load cycle takes effect
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wdog_d = duty_wr ? '0 : wdog_q;
    load = 1'b0;
    if (!go) begin
      state_d = IDLE;
      cnt_d = '0;
      wdog_d = '0;
    end else if (state_q == IDLE) begin
      state_d = RUN;
      load = 1'b1;
    end else begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
      load = tc;
      if (tc && state_q == RUN && !duty_wr) begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_d == WD_W'(WDOG_PERIODS)) state_d = FAILSAFE;
      end
      if (tc && state_q == FAILSAFE && wdog_d == '0) state_d = RUN;
    end
    period_act_d = load ? period_sh_d : period_act_q;
    duty_act_d = load ? duty_sh_d : duty_act_q;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_eff;
    assign duty_eff = state_q == FAILSAFE ? CNT_W'(FAILSAFE_DUTY) : duty_act_q[i];
    assign pwm_d[i] = go && state_q != IDLE && cnt_q < duty_eff;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en)
      rd_data_d = addr == ADDR_CTRL ? CNT_W'(enable_q) :
                  addr == ADDR_PERIOD ? period_sh_q :
                  duty_addr ? duty_sh_q[duty_idx] :
                  addr == ADDR_STATUS ? CNT_W'({failsafe, state_q != IDLE, locked_sync}) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      enable_q <= 1'b0;
      period_sh_q <= CNT_W'(PERIOD_RST);
      period_act_q <= CNT_W'(PERIOD_RST);
      duty_sh_q <= '{default: '0};
      duty_act_q <= '{default: '0};
      cnt_q <= '0;
      wdog_q <= '0;
      rd_data_q <= '0;
      pwm_q <= '0;
    end else begin
      state_q <= state_d;
      enable_q <= enable_d;
      period_sh_q <= period_sh_d;
      period_act_q <= period_act_d;
      duty_sh_q <= duty_sh_d;
      duty_act_q <= duty_act_d;
      cnt_q <= cnt_d;
      wdog_q <= wdog_d;
      rd_data_q <= rd_data_d;
      pwm_q <= pwm_d;
    end
  end

  assign rd_data = rd_data_q;
  assign pwm_out = pwm_q;
  assign failsafe = state_q == FAILSAFE;
endmodule
